// File: rtl/step_motor_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// step_motor_ramp_sequencer
//
// Drives a single-step pulse generator through a complete move. The block
// reads a per-step period from an external acceleration table. It issues one
// trig_start pulse per step, with a stable spd_cnt_period, and then follows
// the generator's busy output until that step has finished. The table index
// climbs over the first L steps, holds at L-1 while cruising and mirrors back
// down for the last L steps. This gives a symmetric accelerate/cruise/
// decelerate profile. A short move folds the ramp at its midpoint.
//
// Handshake with the pulse generator: trig_start is a one-cycle request. The
// step counts as accepted once pulse_busy is seen high, and as complete once
// pulse_busy is seen low again. If pulse_busy never rises within BUSY_TIMEOUT
// cycles, the move is aborted with the sticky err_timeout flag set.
//
// Ports:
//   sys_clk, sys_rst_n     clock, asynchronous active-low reset
//   cmd_start / cmd_stop   single-cycle move / stop requests
//   cmd_step_total         number of steps in the move
//   cmd_dir                direction for the move
//   cmd_ramp_len           table entries used for the ramp (0 treated as 1)
//   tbl_rd_addr            acceleration table address
//   tbl_rd_data            table data, valid one cycle after the address
//   trig_start             step trigger to the pulse generator
//   spd_cnt_period         period for the pulse generator, floored at MIN_PERIOD
//   pulse_busy             busy_state from the pulse generator
//   motor_dir              direction pin
//   seq_busy               move in progress
//   seq_done               one-cycle completion strobe
//   seq_stopped            last move was ended by cmd_stop
//   err_timeout            sticky fault: pulse_busy never rose after a trigger
//   steps_done             completed steps in the current/last move
// -----------------------------------------------------------------------------
module step_motor_ramp_sequencer #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] MIN_PERIOD   = 32'd8,
    parameter logic [15:0] DIR_SETUP    = 16'd50,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [31:0]       cmd_step_total,
    input  logic              cmd_dir,
    input  logic [ADDR_W-1:0] cmd_ramp_len,
    output logic [ADDR_W-1:0] tbl_rd_addr,
    input  logic [31:0]       tbl_rd_data,
    output logic              trig_start,
    output logic [31:0]       spd_cnt_period,
    input  logic              pulse_busy,
    output logic              motor_dir,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_stopped,
    output logic              err_timeout,
    output logic [31:0]       steps_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_FETCH, S_LOAD, S_TRIG, S_WAIT_HI, S_WAIT_LO, S_DONE
    } state_t;

    state_t      state;
    logic [31:0] total_r;
    logic [31:0] ramp_last;     // L-1, with L = max(cmd_ramp_len, 1)
    logic [15:0] cnt;           // shared by the SETUP delay and the WAIT_HI timeout
    logic        stop_pending;
    logic [31:0] steps_next;

    assign steps_next = steps_done + 32'd1;

    // Table index for step k: min(k, total-k-1, L-1). The comparisons are done
    // in full 32 bits, and the result is truncated to ADDR_W only at the point
    // of use.
    function automatic logic [31:0] pick_idx(input logic [31:0] k,
                                             input logic [31:0] total,
                                             input logic [31:0] last);
        logic [31:0] m;
        logic [31:0] r1;
        m  = k;
        r1 = total - k - 32'd1;
        if (r1 < m)   m = r1;
        if (last < m) m = last;
        return m;
    endfunction

    // The address is registered on the way into FETCH. The table therefore
    // sees it during FETCH, and its data is valid during LOAD.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= S_IDLE;
            total_r        <= '0;
            ramp_last      <= '0;
            cnt            <= '0;
            stop_pending   <= 1'b0;
            tbl_rd_addr    <= '0;
            trig_start     <= 1'b0;
            spd_cnt_period <= MIN_PERIOD;
            motor_dir      <= 1'b0;
            seq_busy       <= 1'b0;
            seq_done       <= 1'b0;
            seq_stopped    <= 1'b0;
            err_timeout    <= 1'b0;
            steps_done     <= '0;
        end else begin
            trig_start <= 1'b0;
            seq_done   <= 1'b0;

            if (cmd_stop && state != S_IDLE && state != S_DONE)
                stop_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        total_r      <= cmd_step_total;
                        ramp_last    <= (cmd_ramp_len == '0) ? 32'd0
                                                             : 32'(cmd_ramp_len) - 32'd1;
                        motor_dir    <= cmd_dir;
                        steps_done   <= '0;
                        seq_stopped  <= 1'b0;
                        err_timeout  <= 1'b0;
                        stop_pending <= 1'b0;
                        seq_busy     <= 1'b1;
                        cnt          <= '0;
                        state        <= (cmd_step_total == 32'd0) ? S_DONE : S_SETUP;
                    end
                end
                S_SETUP: begin
                    // A stop before any pulse abandons the move right away.
                    if (cmd_stop || stop_pending) begin
                        seq_stopped <= 1'b1;
                        state       <= S_DONE;
                    end else if (cnt == DIR_SETUP - 16'd1) begin
                        tbl_rd_addr <= ADDR_W'(pick_idx(steps_done, total_r, ramp_last));
                        state       <= S_FETCH;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    spd_cnt_period <= (tbl_rd_data < MIN_PERIOD) ? MIN_PERIOD : tbl_rd_data;
                    state          <= S_TRIG;
                end
                S_TRIG: begin
                    trig_start <= 1'b1;
                    cnt        <= '0;
                    state      <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (pulse_busy) begin
                        state <= S_WAIT_LO;
                    end else if (cnt == BUSY_TIMEOUT - 16'd1) begin
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (!pulse_busy) begin
                        steps_done <= steps_next;
                        // Finishing the final step wins over a coincident stop.
                        if (steps_next == total_r) begin
                            state <= S_DONE;
                        end else if (stop_pending || cmd_stop) begin
                            seq_stopped <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            tbl_rd_addr <= ADDR_W'(pick_idx(steps_next, total_r, ramp_last));
                            state       <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    seq_done <= 1'b1;
                    seq_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_motor_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for step_motor_ramp_sequencer. The bench provides:
//   - a synchronous acceleration table with one cycle of latency;
//   - a small pulse generator model whose busy pulse can be switched off;
//   - a monitor that logs spd_cnt_period at each trig_start.
// -----------------------------------------------------------------------------
module tb_step_motor_ramp_sequencer;

    localparam int ADDR_W = 8;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              cmd_start;
    logic              cmd_stop;
    logic [31:0]       cmd_step_total;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_ramp_len;
    logic [ADDR_W-1:0] tbl_rd_addr;
    logic [31:0]       tbl_rd_data;
    logic              trig_start;
    logic [31:0]       spd_cnt_period;
    logic              pulse_busy;
    logic              motor_dir;
    logic              seq_busy;
    logic              seq_done;
    logic              seq_stopped;
    logic              err_timeout;
    logic [31:0]       steps_done;

    step_motor_ramp_sequencer dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_step_total (cmd_step_total),
        .cmd_dir        (cmd_dir),
        .cmd_ramp_len   (cmd_ramp_len),
        .tbl_rd_addr    (tbl_rd_addr),
        .tbl_rd_data    (tbl_rd_data),
        .trig_start     (trig_start),
        .spd_cnt_period (spd_cnt_period),
        .pulse_busy     (pulse_busy),
        .motor_dir      (motor_dir),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .seq_stopped    (seq_stopped),
        .err_timeout    (err_timeout),
        .steps_done     (steps_done)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish (got hang, expected finish)");
        $fatal(1);
    end

    // acceleration table: table[i] = 1000 - 100*i for the entries in use
    logic [31:0] tbl_mem [0:255];
    always_ff @(posedge sys_clk) tbl_rd_data <= tbl_mem[tbl_rd_addr];

    // pulse generator model: busy for a few cycles after each trigger
    logic       busy_en;
    logic [2:0] bcnt;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pulse_busy <= 1'b0;
            bcnt       <= '0;
        end else if (busy_en && trig_start) begin
            pulse_busy <= 1'b1;
            bcnt       <= 3'd3;
        end else if (pulse_busy) begin
            if (bcnt == 3'd0) pulse_busy <= 1'b0;
            else              bcnt <= bcnt - 3'd1;
        end
    end

    // monitor: period logged at every trigger, strobes counted
    logic [31:0] per_log [0:4095];
    int trig_cnt = 0;
    int done_cnt = 0;
    always @(negedge sys_clk) begin
        if (trig_start) begin
            per_log[trig_cnt % 4096] = spd_cnt_period;
            trig_cnt++;
        end
        if (seq_done) done_cnt++;
    end

    // scoreboard counters
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " trig_start"},  32'(trig_start),  0);
        check({tag, " period"},      spd_cnt_period,   8);
        check({tag, " motor_dir"},   32'(motor_dir),   0);
        check({tag, " seq_busy"},    32'(seq_busy),    0);
        check({tag, " seq_done"},    32'(seq_done),    0);
        check({tag, " seq_stopped"}, 32'(seq_stopped), 0);
        check({tag, " err_timeout"}, 32'(err_timeout), 0);
        check({tag, " steps_done"},  steps_done,       0);
        check({tag, " tbl_rd_addr"}, 32'(tbl_rd_addr), 0);
    endtask

    // directed vectors
    typedef struct {
        int total;
        int dir;
        int ramp_len;
        int stop_trig;    // raise cmd_stop (and a stray cmd_start) at this trigger, 0 = never
        int stop_cyc;     // raise cmd_stop this many cycles after start, 0 = never
        int exp_steps;
        int exp_stopped;
        int exp_trigs;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    int   exp_per [NV][10];

    task automatic run_move(input vec_t v, input int per[10], input string tag);
        int   t0;
        int   d0;
        int   lt;
        logic got_done;
        t0       = trig_cnt;
        d0       = done_cnt;
        lt       = 0;
        got_done = 1'b0;
        @(negedge sys_clk);
        cmd_step_total = 32'(v.total);
        cmd_dir        = v.dir[0];
        cmd_ramp_len   = ADDR_W'(v.ramp_len);
        cmd_start      = 1'b1;
        @(negedge sys_clk);
        cmd_start = 1'b0;
        for (int cyc = 1; cyc < 20000 && !got_done; cyc++) begin
            @(negedge sys_clk);
            cmd_stop  = 1'b0;
            cmd_start = 1'b0;
            if (trig_start) lt++;
            if (v.stop_trig != 0 && trig_start && lt == v.stop_trig) begin
                cmd_stop  = 1'b1;
                cmd_start = 1'b1;          // must be ignored mid-move
                cmd_dir   = ~v.dir[0];
            end
            if (v.stop_cyc != 0 && cyc == v.stop_cyc) cmd_stop = 1'b1;
            if (seq_done) got_done = 1'b1;
        end
        cmd_stop  = 1'b0;
        cmd_start = 1'b0;
        @(negedge sys_clk);
        check({tag, " done_seen"},   32'(got_done),        1);
        check({tag, " steps_done"},  steps_done,           32'(v.exp_steps));
        check({tag, " seq_stopped"}, 32'(seq_stopped),     32'(v.exp_stopped));
        check({tag, " err_timeout"}, 32'(err_timeout),     0);
        check({tag, " seq_busy"},    32'(seq_busy),        0);
        check({tag, " motor_dir"},   32'(motor_dir),       32'(v.dir));
        check({tag, " trig_count"},  32'(trig_cnt - t0),   32'(v.exp_trigs));
        check({tag, " done_count"},  32'(done_cnt - d0),   1);
        for (int i = 0; i < v.exp_trigs && i < 10; i++)
            check($sformatf("%s period[%0d]", tag, i), per_log[(t0 + i) % 4096], 32'(per[i]));
    endtask

    initial begin
        int   t0;
        int   n;
        int   first;
        int   dn;
        int   tn;
        logic seen;

        sys_rst_n      = 1'b0;
        cmd_start      = 1'b0;
        cmd_stop       = 1'b0;
        cmd_step_total = '0;
        cmd_dir        = 1'b0;
        cmd_ramp_len   = '0;
        busy_en        = 1'b1;
        for (int i = 0; i < 256; i++) tbl_mem[i] = (i < 10) ? 32'(1000 - 100 * i) : 32'd100;

        vecs[0] = '{10, 0, 4, 0, 0, 10, 0, 10};
        vecs[1] = '{3, 1, 8, 0, 0, 3, 0, 3};
        vecs[2] = '{100, 0, 4, 5, 0, 5, 1, 5};
        vecs[3] = '{4, 1, 0, 0, 0, 4, 0, 4};
        vecs[4] = '{5, 0, 4, 0, 5, 0, 1, 0};
        vecs[5] = '{2, 1, 2, 2, 0, 2, 0, 2};
        exp_per = '{'{1000, 900, 800, 700, 700, 700, 700, 800, 900, 1000},
                    '{1000, 900, 1000, 0, 0, 0, 0, 0, 0, 0},
                    '{1000, 900, 800, 700, 700, 0, 0, 0, 0, 0},
                    '{1000, 1000, 1000, 1000, 0, 0, 0, 0, 0, 0},
                    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{1000, 1000, 0, 0, 0, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge sys_clk);
        check_reset("reset");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        for (int v = 0; v < NV; v++)
            run_move(vecs[v], exp_per[v], $sformatf("vec%0d", v));

        // Timeout: floor applied to a short period, and the generator never answers.
        busy_en    = 1'b0;
        tbl_mem[0] = 32'd3;
        t0         = trig_cnt;
        @(negedge sys_clk);
        cmd_step_total = 32'd5;
        cmd_dir        = 1'b0;
        cmd_ramp_len   = 8'd1;
        cmd_start      = 1'b1;
        @(negedge sys_clk);
        cmd_start = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sys_clk);
            if (trig_start) seen = 1'b1;
        end
        check("tmo trig_seen", 32'(seen), 1);
        check("tmo period_floor", spd_cnt_period, 8);
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge sys_clk);
            if (err_timeout) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check("tmo cycles_to_err", 32'(n), 16);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge sys_clk);
            if (seq_done) seen = 1'b1;
        end
        check("tmo done_seen", 32'(seen), 1);
        @(negedge sys_clk);
        check("tmo err_sticky", 32'(err_timeout), 1);
        check("tmo steps_done", steps_done, 0);
        check("tmo trig_count", 32'(trig_cnt - t0), 1);
        check("tmo seq_busy", 32'(seq_busy), 0);
        busy_en    = 1'b1;
        tbl_mem[0] = 32'd1000;

        // Zero-length move: seq_done two cycles after cmd_start, no trigger.
        t0 = trig_cnt;
        @(negedge sys_clk);
        cmd_step_total = 32'd0;
        cmd_dir        = 1'b1;
        cmd_start      = 1'b1;
        first          = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            cmd_start = 1'b0;
            if (seq_done && first == 0) first = i;
        end
        check("zero done_latency", 32'(first), 2);
        check("zero motor_dir", 32'(motor_dir), 1);
        check("zero trig_count", 32'(trig_cnt - t0), 0);
        check("zero err_cleared", 32'(err_timeout), 0);

        // Direction change needs at least 50 cycles before the first trigger.
        @(negedge sys_clk);
        cmd_step_total = 32'd1;
        cmd_dir        = 1'b0;
        cmd_ramp_len   = 8'd1;
        cmd_start      = 1'b1;
        dn             = 0;
        tn             = 0;
        seen           = 1'b0;
        for (int i = 1; i < 500 && !seen; i++) begin
            @(negedge sys_clk);
            cmd_start = 1'b0;
            if (!motor_dir && dn == 0) dn = i;
            if (trig_start && tn == 0) tn = i;
            if (seq_done) seen = 1'b1;
        end
        check("dir trig_seen", 32'(tn != 0), 1);
        check("dir setup_gap_ge_50", 32'((tn - dn) >= 50), 1);
        check("dir done_seen", 32'(seen), 1);
        @(negedge sys_clk);
        check("dir steps_done", steps_done, 1);

        // Reset during WAIT_LO: outputs drop immediately; a fresh move runs.
        @(negedge sys_clk);
        cmd_step_total = 32'd10;
        cmd_dir        = 1'b1;
        cmd_ramp_len   = 8'd4;
        cmd_start      = 1'b1;
        seen           = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge sys_clk);
            cmd_start = 1'b0;
            if (pulse_busy) seen = 1'b1;
        end
        check("rst busy_seen", 32'(seen), 1);
        @(negedge sys_clk);
        check("rst pre_busy", 32'(seq_busy), 1);
        #2 sys_rst_n = 1'b0;
        #1 check_reset("midrst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_move(vecs[0], exp_per[0], "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/step_motor_ramp_sequencer.md
Name: step_motor_ramp_sequencer

Overview:
- Upstream driver of the single-step pulse generator.
- Accepts a move command (step count, direction, ramp length) and reads per-step period values from an external acceleration table.
- Issues one trig_start pulse plus a stable spd_cnt_period per step, then tracks the generator's busy output until the step completes.
- Produces a symmetric accelerate/cruise/decelerate profile and reports progress, completion and faults to the control register block.

Parameters:
- ADDR_W, 8, acceleration table address width (max ramp length 2^ADDR_W entries).
- MIN_PERIOD, 32'd8, floor applied to every period sent downstream.
- DIR_SETUP, 16'd50, sys_clk cycles from motor_dir update to first trig_start.
- BUSY_TIMEOUT, 16'd16, max cycles from trig_start to pulse_busy going high.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous reset, active-low
- cmd_start  in  1  single-cycle move request
- cmd_stop  in  1  single-cycle stop request
- cmd_step_total  in  32  steps to issue
- cmd_dir  in  1  direction for the move
- cmd_ramp_len  in  ADDR_W  table entries used for the ramp
- tbl_rd_addr  out  ADDR_W  table read address
- tbl_rd_data  in  32  table data, valid 1 cycle after address
- trig_start  out  1  step trigger to the pulse generator
- spd_cnt_period  out  32  period for the pulse generator
- pulse_busy  in  1  busy_state from the pulse generator
- motor_dir  out  1  direction pin
- seq_busy  out  1  move in progress
- seq_done  out  1  single-cycle completion strobe
- seq_stopped  out  1  last move ended by cmd_stop
- err_timeout  out  1  sticky fault: pulse_busy never rose
- steps_done  out  32  completed steps in current/last move

Behaviour:
- Reset (sys_clk, sys_rst_n asynchronous active-low): all outputs 0, except spd_cnt_period = MIN_PERIOD. State = IDLE.
- States: IDLE, SETUP, FETCH, LOAD, TRIG, WAIT_HI, WAIT_LO, DONE. All outputs registered.
- IDLE:
  - On cmd_start, latch total, dir and L = max(cmd_ramp_len, 1).
  - Set motor_dir, clear steps_done, seq_stopped, err_timeout and stop_pending; seq_busy = 1.
  - If total == 0, go to DONE, otherwise go to SETUP.
  - cmd_start in any other state is ignored.
- SETUP: wait DIR_SETUP cycles (counter from 0 to DIR_SETUP-1), then go to FETCH.
- Index selection for step k = steps_done: r = total - k, idx = min(k, r-1, L-1). All compares are unsigned 32-bit; idx is truncated to ADDR_W only after the min.
- FETCH: drive tbl_rd_addr = idx, go to LOAD.
- LOAD: spd_cnt_period = (tbl_rd_data < MIN_PERIOD) ? MIN_PERIOD : tbl_rd_data. Go to TRIG.
- TRIG: trig_start = 1 for exactly one cycle, then go to WAIT_HI.
  - spd_cnt_period holds from LOAD until the next LOAD.
- WAIT_HI: wait for pulse_busy = 1, then go to WAIT_LO.
  - Cycle counter starts on entry. If it reaches BUSY_TIMEOUT, set err_timeout and go to DONE; steps_done is not incremented.
- WAIT_LO: on pulse_busy = 0, steps_done += 1.
  - If steps_done+1 == total or stop_pending, go to DONE; otherwise go to FETCH.
- Stop handling:
  - cmd_stop in SETUP..WAIT_LO sets stop_pending; a stop arriving in SETUP ends the move in DONE with no pulses.
  - An in-flight step always completes.
  - seq_stopped = 1 if the move ends via stop_pending.
  - cmd_stop in IDLE or DONE is ignored.
  - Simultaneous cmd_stop and the final step completing: treated as normal completion, seq_stopped = 0.
- DONE: seq_done = 1 for one cycle, seq_busy = 0, go to IDLE. motor_dir holds its value.
- Per-step overhead beyond the generator: FETCH + LOAD + TRIG + generator latency. No requirement on exact step rate.
- Reset mid-move: immediate return to reset values; trig_start is never left high.

Test Plan:
- Table[i] = 1000 - 100*i, total = 10, L = 4, MIN_PERIOD = 8 -> periods issued 1000, 900, 800, 700, 700, 700, 700, 800, 900, 1000; steps_done = 10; one seq_done pulse; seq_stopped = 0.
- total = 3, L = 8 -> periods table[0], table[1], table[0] (ramp folded); exactly 3 trig_start pulses.
- table[0] = 3 -> spd_cnt_period = 8; pulse_busy tied low -> err_timeout = 1 after 16 cycles in WAIT_HI, seq_done pulses, steps_done = 0.
- cmd_stop asserted during step 5 of 100 -> step 5 completes, steps_done = 5, seq_stopped = 1; a cmd_start during the move is ignored.
- total = 0 -> seq_done 2 cycles after cmd_start, no trig_start; cmd_dir = 1 -> motor_dir = 1 and first trig_start no earlier than 50 cycles after the motor_dir change.
- Assert sys_rst_n low in WAIT_LO -> all outputs at reset values in the same cycle; a new move after release runs normally.
